// File: rtl/conv_dist_ctrl.sv
// Job sequencer for the CONV distributer: gates the feature stream into m1, frames first/last, drains, signals done.
// Optional stall counter enabled by defining CONV_DIST_CTRL_PERF_EN.
module conv_dist_ctrl #(
    parameter int PW   = 8,
    parameter int LW   = 10,
    parameter int PIPE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic [PW-1:0] cfg_passes,
    input  logic [LW-1:0] cfg_len,
    input  logic [LW-1:0] cfg_base,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          src_valid,
    output logic          src_ready,
    input  logic          dst_stall,
    output logic          m1_valid,
    output logic          m1_first,
    output logic          m1_last,
    output logic [LW-1:0] info_base,
    output logic [LW-1:0] info_size,
    output logic [31:0]   perf_stall
);

    localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t        state;
    logic [PW-1:0] passes_r;
    logic [PW-1:0] pass_cnt;
    logic [LW-1:0] beat_cnt;
    logic [DW-1:0] drain_cnt;
    logic          fire;
    logic          beat_end;
    logic          pass_end;

    // The handshake is combinational so a beat can move every cycle; info_size doubles as the latched length.
    assign fire      = (state == S_STREAM) && src_valid && !dst_stall;
    assign beat_end  = (beat_cnt == info_size - 1'b1);
    assign pass_end  = (pass_cnt == passes_r - 1'b1);
    assign src_ready = fire;
    assign m1_valid  = fire;
    assign m1_first  = fire && (pass_cnt == '0) && (beat_cnt == '0);
    assign m1_last   = fire && pass_end && beat_end;

    // NOTE: all state and registered outputs use <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            passes_r  <= '0;
            info_base <= '0;
            info_size <= '0;
            pass_cnt  <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        passes_r  <= cfg_passes;
                        info_size <= cfg_len;
                        info_base <= cfg_base;
                        pass_cnt  <= '0;
                        beat_cnt  <= '0;
                        drain_cnt <= '0;
                        busy      <= 1'b1;
                        if (cfg_passes == '0 || cfg_len == '0) begin
                            // Degenerate job: report it and finish without issuing beats.
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (fire) begin
                        if (beat_end) begin
                            beat_cnt <= '0;
                            if (pass_end) begin
                                drain_cnt <= '0;
                                state     <= S_DRAIN;
                            end else begin
                                pass_cnt <= pass_cnt + 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DW'(PIPE - 1)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV_DIST_CTRL_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (state == S_IDLE && cfg_start) begin
            perf_cnt <= '0;
        end else if (state == S_STREAM && !fire && perf_cnt != 32'hFFFF_FFFF) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_stall = perf_cnt;
`else
    assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_conv_dist_ctrl.sv
// Directed bench for conv_dist_ctrl: a job table run against a cycle-level expectation, plus reset and
// degenerate-job sequences.
module tb_conv_dist_ctrl;

    localparam int PW   = 8;
    localparam int LW   = 10;
    localparam int PIPE = 4;

    typedef struct {
        logic [PW-1:0] passes;
        logic [LW-1:0] len;
        logic [LW-1:0] base;
        logic [15:0]   valid_pat;
        logic [15:0]   stall_pat;
        bit            poke;
    } job_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [PW-1:0] cfg_passes;
    logic [LW-1:0] cfg_len;
    logic [LW-1:0] cfg_base;
    logic          busy, done, err;
    logic          src_valid, src_ready, dst_stall;
    logic          m1_valid, m1_first, m1_last;
    logic [LW-1:0] info_base, info_size;
    logic [31:0]   perf_stall;

    int checks = 0;
    int errors = 0;

    conv_dist_ctrl #(.PW(PW), .LW(LW), .PIPE(PIPE)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_passes(cfg_passes),
        .cfg_len   (cfg_len),
        .cfg_base  (cfg_base),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .dst_stall (dst_stall),
        .m1_valid  (m1_valid),
        .m1_first  (m1_first),
        .m1_last   (m1_last),
        .info_base (info_base),
        .info_size (info_size),
        .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_perf(input int gaps);
`ifdef CONV_DIST_CTRL_PERF_EN
        return 32'(gaps);
`else
        return 32'd0;
`endif
    endfunction

    task automatic run_job(input job_t v);
        int  total, beat, gaps, since_last;
        bit  streaming, finished;
        total = int'(v.passes) * int'(v.len);

        cfg_passes = v.passes;
        cfg_len    = v.len;
        cfg_base   = v.base;
        cfg_start  = 1'b1;
        src_valid  = 1'b0;
        dst_stall  = 1'b0;
        #1;
        check("idle_busy", busy, 1'b0);
        next_cycle();
        cfg_start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("info_base", info_base, v.base);
        check("info_size", info_size, v.len);

        if (total == 0) begin
            src_valid = 1'b1;
            #1;
            check("zero_err", err, 1'b1);
            check("zero_done", done, 1'b1);
            check("zero_no_beat", m1_valid, 1'b0);
            next_cycle();
            #1;
            check("zero_done_clear", done, 1'b0);
            check("zero_busy_clear", busy, 1'b0);
            check("zero_err_sticky", err, 1'b1);
            check("zero_no_beat2", m1_valid, 1'b0);
            check("zero_perf", perf_stall, 32'd0);
            src_valid = 1'b0;
            return;
        end

        check("err_cleared", err, 1'b0);
        beat = 0;
        gaps = 0;
        since_last = 0;
        streaming = 1'b1;
        finished = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            src_valid = v.valid_pat[cyc % 16];
            dst_stall = v.stall_pat[cyc % 16];
            if (v.poke && (cyc == 2 || (!streaming && since_last == 0))) begin
                cfg_start  = 1'b1;
                cfg_passes = 8'd9;
                cfg_len    = 10'd7;
                cfg_base   = ~v.base;
            end else begin
                cfg_start = 1'b0;
            end
            #1;
            if (streaming) begin
                check("m1_valid", m1_valid, src_valid && !dst_stall);
                check("src_ready", src_ready, src_valid && !dst_stall);
                check("stream_done", done, 1'b0);
                if (src_valid && !dst_stall) begin
                    check("m1_first", m1_first, beat == 0);
                    check("m1_last", m1_last, beat == total - 1);
                    beat++;
                    if (beat == total) streaming = 1'b0;
                end else begin
                    check("gap_first", m1_first, 1'b0);
                    check("gap_last", m1_last, 1'b0);
                    gaps++;
                end
            end else begin
                since_last++;
                check("drain_m1_valid", m1_valid, 1'b0);
                check("drain_busy", busy, 1'b1);
                if (since_last == PIPE + 1) begin
                    check("done_pulse", done, 1'b1);
                    finished = 1'b1;
                end else begin
                    check("drain_done", done, 1'b0);
                end
            end
            next_cycle();
        end
        if (!finished) check("job_timeout", 32'd0, 32'd1);

        cfg_start = 1'b0;
        src_valid = 1'b0;
        dst_stall = 1'b0;
        #1;
        check("done_one_cycle", done, 1'b0);
        check("idle_after_job", busy, 1'b0);
        check("info_base_held", info_base, v.base);
        check("info_size_held", info_size, v.len);
        check("perf_stall", perf_stall, exp_perf(gaps));
        next_cycle();
        check("perf_stall_held", perf_stall, exp_perf(gaps));
    endtask

    job_t jobs[7];

    initial begin
        jobs[0] = '{passes: 8'd2, len: 10'd3, base: 10'h040, valid_pat: 16'hFFFF, stall_pat: 16'h0000, poke: 1'b0};
        jobs[1] = '{passes: 8'd2, len: 10'd3, base: 10'h055, valid_pat: 16'h5555, stall_pat: 16'h0700, poke: 1'b0};
        jobs[2] = '{passes: 8'd1, len: 10'd1, base: 10'h3FF, valid_pat: 16'hFFFF, stall_pat: 16'h0000, poke: 1'b0};
        jobs[3] = '{passes: 8'd4, len: 10'd0, base: 10'h123, valid_pat: 16'hFFFF, stall_pat: 16'h0000, poke: 1'b0};
        jobs[4] = '{passes: 8'd1, len: 10'd5, base: 10'h200, valid_pat: 16'hFFFF, stall_pat: 16'h0F0F, poke: 1'b0};
        jobs[5] = '{passes: 8'd0, len: 10'd6, base: 10'h0AA, valid_pat: 16'hFFFF, stall_pat: 16'h0000, poke: 1'b0};
        jobs[6] = '{passes: 8'd3, len: 10'd2, base: 10'h1C3, valid_pat: 16'hFFFF, stall_pat: 16'h0000, poke: 1'b1};

        rst        = 1'b1;
        cfg_start  = 1'b0;
        cfg_passes = '0;
        cfg_len    = '0;
        cfg_base   = '0;
        src_valid  = 1'b0;
        dst_stall  = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_info_base", info_base, '0);
        check("rst_info_size", info_size, '0);
        check("rst_perf", perf_stall, 32'd0);
        next_cycle();

        for (int i = 0; i < 7; i++) run_job(jobs[i]);

        // Reset in the middle of pass 0, beat 2: job is abandoned with no done pulse.
        cfg_passes = 8'd2;
        cfg_len    = 10'd3;
        cfg_base   = 10'h0F0;
        cfg_start  = 1'b1;
        next_cycle();
        cfg_start = 1'b0;
        src_valid = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        check("pre_rst_beat2", m1_valid, 1'b1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < PIPE + 3; k++) begin
            #1;
            check("post_rst_busy", busy, 1'b0);
            check("post_rst_done", done, 1'b0);
            check("post_rst_m1_valid", m1_valid, 1'b0);
            check("post_rst_info", info_base, '0);
            next_cycle();
        end
        src_valid = 1'b0;

        run_job(jobs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
